// File: rtl/cram_ring_buffer_if.sv
// Push/pop handshake bundle for the trace-capture ring buffer.
// The source side (master) drives beats and pop requests; the buffer (slave) answers.
interface cram_ring_buffer_if #(
   parameter int WORD_WIDTH = 8,
   parameter int IN_COUNT   = 16,
   parameter int OUT_COUNT  = 4
) ();
   localparam int POP_W = $clog2(OUT_COUNT + 1);

   logic                            push_valid;
   logic                            push_ready;
   logic [IN_COUNT*WORD_WIDTH-1:0]  push_data;
   logic [IN_COUNT-1:0]             push_mask;
   logic                            pop_req;
   logic [POP_W-1:0]                pop_cnt;
   logic                            pop_ack;
   logic                            rd_valid;
   logic [OUT_COUNT*WORD_WIDTH-1:0] rd_data;

   modport master (
      output push_valid, push_data, push_mask, pop_req, pop_cnt,
      input  push_ready, pop_ack, rd_valid, rd_data
   );

   modport slave (
      input  push_valid, push_data, push_mask, pop_req, pop_cnt,
      output push_ready, pop_ack, rd_valid, rd_data
   );
endinterface

// File: rtl/cram_ring_buffer.sv
// Circular trace-capture RAM: masked multi-lane push with lane compaction,
// multi-word pop with one-cycle read latency, occupancy and drop tracking.
module cram_ring_buffer #(
   parameter int WORD_COUNT   = 64,
   parameter int WORD_WIDTH   = 8,
   parameter int IN_COUNT     = 16,
   parameter int OUT_COUNT    = 4,
   parameter int DROP_ON_FULL = 0,
   parameter int DROP_CNT_W   = 16,
   localparam int PTR_W = $clog2(WORD_COUNT),
   localparam int LVL_W = PTR_W + 1,
   localparam int POP_W = $clog2(OUT_COUNT + 1)
) (
   input  logic                  io_clk,
   input  logic                  io_resetn,
   input  logic                  io_clear,
   cram_ring_buffer_if.slave     bus,
   output logic [LVL_W-1:0]      io_level,
   output logic                  io_empty,
   output logic                  io_full,
   output logic                  io_overflow,
   output logic [DROP_CNT_W-1:0] io_drop_cnt
);

   logic [WORD_WIDTH-1:0]           mem [WORD_COUNT];
   logic [PTR_W-1:0]                wr_ptr;
   logic [PTR_W-1:0]                rd_ptr;
   logic [PTR_W-1:0]                rank [IN_COUNT];
   logic [LVL_W-1:0]                push_n;
   logic [LVL_W-1:0]                pop_taken;
   logic [LVL_W-1:0]                level_next;
   logic [OUT_COUNT*WORD_WIDTH-1:0] rd_next;
   logic                            fits;
   logic                            push_fire;
   logic                            push_drop;

   // Each enabled lane lands at wr_ptr plus the number of enabled lanes below it.
   always_comb begin
      push_n = '0;
      for (int i = 0; i < IN_COUNT; i++) begin
         rank[i] = push_n[PTR_W-1:0];
         push_n  = push_n + LVL_W'(bus.push_mask[i]);
      end
   end

   assign fits           = (LVL_W'(WORD_COUNT) - io_level) >= push_n;
   assign bus.push_ready = (DROP_ON_FULL != 0) ? 1'b1 : fits;
   assign push_fire      = bus.push_valid && fits && !io_clear;
   assign push_drop      = (DROP_ON_FULL != 0) && bus.push_valid && !fits && !io_clear;
   assign bus.pop_ack    = bus.pop_req && (io_level >= LVL_W'(bus.pop_cnt)) && !io_clear;
   assign pop_taken      = bus.pop_ack ? LVL_W'(bus.pop_cnt) : '0;
   assign level_next     = io_level + (push_fire ? push_n : '0) - pop_taken;

   // Pops only touch occupied words, so reading pre-write contents is always correct.
   always_comb begin
      rd_next = '0;
      for (int j = 0; j < OUT_COUNT; j++) begin
         if (POP_W'(j) < bus.pop_cnt) begin
            rd_next[j*WORD_WIDTH +: WORD_WIDTH] = mem[rd_ptr + PTR_W'(j)];
         end
      end
   end

   always_ff @(posedge io_clk) begin
      if (push_fire) begin
         for (int i = 0; i < IN_COUNT; i++) begin
            if (bus.push_mask[i]) begin
               mem[wr_ptr + rank[i]] <= bus.push_data[i*WORD_WIDTH +: WORD_WIDTH];
            end
         end
      end
   end

   always_ff @(posedge io_clk or negedge io_resetn) begin
      if (!io_resetn) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         io_level     <= '0;
         io_empty     <= 1'b1;
         io_full      <= 1'b0;
         io_overflow  <= 1'b0;
         io_drop_cnt  <= '0;
         bus.rd_valid <= 1'b0;
         bus.rd_data  <= '0;
      end else if (io_clear) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         io_level     <= '0;
         io_empty     <= 1'b1;
         io_full      <= 1'b0;
         io_overflow  <= 1'b0;
         io_drop_cnt  <= '0;
         bus.rd_valid <= 1'b0;
      end else begin
         if (push_fire) begin
            wr_ptr <= wr_ptr + push_n[PTR_W-1:0];
         end
         if (bus.pop_ack) begin
            rd_ptr      <= rd_ptr + PTR_W'(bus.pop_cnt);
            bus.rd_data <= rd_next;
         end
         bus.rd_valid <= bus.pop_ack;
         io_level     <= level_next;
         io_empty     <= (level_next == '0);
         io_full      <= (level_next == LVL_W'(WORD_COUNT));
         // Drop counter saturates so a long overload never wraps back to a small count.
         if (push_drop) begin
            io_overflow <= 1'b1;
            if (io_drop_cnt != '1) begin
               io_drop_cnt <= io_drop_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_cram_ring_buffer.sv
// Directed bench for cram_ring_buffer: one backpressure instance and one
// drop-on-full instance, selected by 'sel', sharing one stimulus set.
module tb_cram_ring_buffer;

   logic         io_clk;
   logic         io_resetn;
   logic         clear;
   logic         sel;
   logic         push_valid;
   logic [15:0]  push_mask;
   logic [127:0] push_data;
   logic         pop_req;
   logic [2:0]   pop_cnt;

   int compared;
   int mismatched;

   cram_ring_buffer_if #(.WORD_WIDTH(8), .IN_COUNT(16), .OUT_COUNT(4)) bus_bp ();
   cram_ring_buffer_if #(.WORD_WIDTH(8), .IN_COUNT(16), .OUT_COUNT(4)) bus_dr ();

   logic [6:0]  level_bp, level_dr;
   logic        empty_bp, empty_dr, full_bp, full_dr, ovf_bp, ovf_dr;
   logic [15:0] drop_bp, drop_dr;

   assign bus_bp.push_valid = push_valid & ~sel;
   assign bus_bp.push_mask  = push_mask;
   assign bus_bp.push_data  = push_data;
   assign bus_bp.pop_req    = pop_req & ~sel;
   assign bus_bp.pop_cnt    = pop_cnt;
   assign bus_dr.push_valid = push_valid & sel;
   assign bus_dr.push_mask  = push_mask;
   assign bus_dr.push_data  = push_data;
   assign bus_dr.pop_req    = pop_req & sel;
   assign bus_dr.pop_cnt    = pop_cnt;

   cram_ring_buffer #(
      .WORD_COUNT(64), .WORD_WIDTH(8), .IN_COUNT(16), .OUT_COUNT(4),
      .DROP_ON_FULL(0), .DROP_CNT_W(16)
   ) dut_bp (
      .io_clk(io_clk), .io_resetn(io_resetn), .io_clear(clear & ~sel),
      .bus(bus_bp.slave),
      .io_level(level_bp), .io_empty(empty_bp), .io_full(full_bp),
      .io_overflow(ovf_bp), .io_drop_cnt(drop_bp)
   );

   cram_ring_buffer #(
      .WORD_COUNT(64), .WORD_WIDTH(8), .IN_COUNT(16), .OUT_COUNT(4),
      .DROP_ON_FULL(1), .DROP_CNT_W(16)
   ) dut_dr (
      .io_clk(io_clk), .io_resetn(io_resetn), .io_clear(clear & sel),
      .bus(bus_dr.slave),
      .io_level(level_dr), .io_empty(empty_dr), .io_full(full_dr),
      .io_overflow(ovf_dr), .io_drop_cnt(drop_dr)
   );

   logic        push_ready, pop_ack, rd_valid, empty, full, overflow;
   logic [31:0] rd_data;
   logic [6:0]  level;
   logic [15:0] drop_cnt;

   assign push_ready = sel ? bus_dr.push_ready : bus_bp.push_ready;
   assign pop_ack    = sel ? bus_dr.pop_ack    : bus_bp.pop_ack;
   assign rd_valid   = sel ? bus_dr.rd_valid   : bus_bp.rd_valid;
   assign rd_data    = sel ? bus_dr.rd_data    : bus_bp.rd_data;
   assign level      = sel ? level_dr : level_bp;
   assign empty      = sel ? empty_dr : empty_bp;
   assign full       = sel ? full_dr  : full_bp;
   assign overflow   = sel ? ovf_dr   : ovf_bp;
   assign drop_cnt   = sel ? drop_dr  : drop_bp;

   initial io_clk = 1'b0;
   always #5 io_clk = ~io_clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic pv, input logic [15:0] pm, input logic [127:0] pd,
                                input logic pr, input logic [2:0] pc);
      push_valid = pv;
      push_mask  = pm;
      push_data  = pd;
      pop_req    = pr;
      pop_cnt    = pc;
      #1;
   endtask

   task automatic tick();
      @(posedge io_clk);
      #1;
   endtask

   function automatic logic [127:0] seqData(input logic [7:0] base);
      logic [127:0] d;
      d = '0;
      for (int i = 0; i < 16; i++) d[i*8 +: 8] = base + 8'(i);
      return d;
   endfunction

   initial begin
      logic [127:0] d;
      compared   = 0;
      mismatched = 0;
      sel        = 1'b0;
      clear      = 1'b0;
      io_resetn  = 1'b0;
      applyStimulus(0, 16'h0, '0, 0, 3'd0);
      tick();
      tick();
      checkOutput("rst_level", level, 0);
      checkOutput("rst_empty", empty, 1);
      checkOutput("rst_full", full, 0);
      checkOutput("rst_rd_valid", rd_valid, 0);
      checkOutput("rst_rd_data", rd_data, 0);
      checkOutput("rst_overflow", overflow, 0);
      checkOutput("rst_drop_cnt", drop_cnt, 0);
      io_resetn = 1'b1;
      tick();

      // Sparse mask: lanes 0 and 2 compacted, lane 1 junk must be skipped
      d = '0;
      d[7:0]   = 8'hA0;
      d[15:8]  = 8'hEE;
      d[23:16] = 8'hA2;
      applyStimulus(1, 16'h0005, d, 0, 3'd0);
      checkOutput("sparse_ready", push_ready, 1);
      tick();
      checkOutput("sparse_level", level, 2);
      checkOutput("sparse_empty", empty, 0);
      applyStimulus(0, 16'h0, '0, 1, 3'd2);
      checkOutput("sparse_ack", pop_ack, 1);
      tick();
      checkOutput("sparse_rd_valid", rd_valid, 1);
      checkOutput("sparse_rd_data", rd_data, 32'h0000A2A0);
      checkOutput("sparse_level0", level, 0);
      checkOutput("sparse_empty1", empty, 1);
      applyStimulus(0, 16'h0, '0, 0, 3'd0);
      tick();
      checkOutput("rd_valid_pulse", rd_valid, 0);
      checkOutput("rd_data_hold", rd_data, 32'h0000A2A0);

      // Walk both pointers from 2 to 60, then wrap an 8-word beat
      for (int k = 0; k < 29; k++) begin
         applyStimulus(1, 16'h0003, seqData(8'(k)), 0, 3'd0);
         tick();
         applyStimulus(0, 16'h0, '0, 1, 3'd2);
         tick();
      end
      checkOutput("walk_level", level, 0);
      applyStimulus(1, 16'h00FF, seqData(8'h10), 0, 3'd0);
      tick();
      checkOutput("wrap_level", level, 8);
      applyStimulus(0, 16'h0, '0, 1, 3'd4);
      tick();
      checkOutput("wrap_pop1", rd_data, 32'h13121110);
      applyStimulus(0, 16'h0, '0, 1, 3'd4);
      tick();
      checkOutput("wrap_pop2", rd_data, 32'h17161514);
      checkOutput("wrap_level0", level, 0);

      // Backpressure: fill to 56, a 16-word beat waits until level <= 48
      for (int b = 0; b < 3; b++) begin
         applyStimulus(1, 16'hFFFF, seqData(8'h20), 0, 3'd0);
         tick();
      end
      applyStimulus(1, 16'h00FF, seqData(8'h20), 0, 3'd0);
      tick();
      checkOutput("bp_level56", level, 56);
      applyStimulus(1, 16'hFFFF, seqData(8'h60), 1, 3'd4);
      checkOutput("bp_ready_at56", push_ready, 0);
      checkOutput("bp_ack_at56", pop_ack, 1);
      tick();
      checkOutput("bp_level52", level, 52);
      checkOutput("bp_rd_data", rd_data, 32'h23222120);
      applyStimulus(1, 16'hFFFF, seqData(8'h60), 1, 3'd4);
      checkOutput("bp_ready_at52", push_ready, 0);
      tick();
      checkOutput("bp_level48", level, 48);
      applyStimulus(1, 16'hFFFF, seqData(8'h60), 0, 3'd0);
      checkOutput("bp_ready_at48", push_ready, 1);
      tick();
      checkOutput("bp_level64", level, 64);
      checkOutput("bp_full", full, 1);
      checkOutput("bp_no_overflow", overflow, 0);

      // Clear beats a pop that would otherwise be acknowledged
      clear = 1'b1;
      applyStimulus(0, 16'h0, '0, 1, 3'd4);
      checkOutput("bp_clear_ack", pop_ack, 0);
      tick();
      clear = 1'b0;
      checkOutput("bp_clear_level", level, 0);
      checkOutput("bp_clear_empty", empty, 1);
      checkOutput("bp_clear_full", full, 0);
      checkOutput("bp_clear_rd_valid", rd_valid, 0);

      // Under-level pop refused; simultaneous push 5 / pop 4 from level 10
      applyStimulus(1, 16'h0003, seqData(8'h30), 0, 3'd0);
      tick();
      applyStimulus(0, 16'h0, '0, 1, 3'd3);
      checkOutput("short_pop_ack", pop_ack, 0);
      tick();
      checkOutput("short_pop_rd_valid", rd_valid, 0);
      checkOutput("short_pop_level", level, 2);
      applyStimulus(1, 16'h00FF, seqData(8'h40), 0, 3'd0);
      tick();
      checkOutput("level10", level, 10);
      applyStimulus(1, 16'h001F, seqData(8'h50), 1, 3'd4);
      checkOutput("simul_ack", pop_ack, 1);
      checkOutput("simul_ready", push_ready, 1);
      tick();
      checkOutput("simul_level", level, 11);
      checkOutput("simul_rd_valid", rd_valid, 1);
      checkOutput("simul_rd_data", rd_data, 32'h41403130);
      applyStimulus(0, 16'h0, '0, 1, 3'd0);
      checkOutput("pop0_ack", pop_ack, 1);
      tick();
      checkOutput("pop0_rd_valid", rd_valid, 1);
      checkOutput("pop0_rd_data", rd_data, 0);
      checkOutput("pop0_level", level, 11);

      // Reset lands between an ack and its read-data cycle
      applyStimulus(0, 16'h0, '0, 1, 3'd1);
      checkOutput("rstmid_ack", pop_ack, 1);
      #2;
      io_resetn = 1'b0;
      tick();
      checkOutput("rstmid_rd_valid", rd_valid, 0);
      checkOutput("rstmid_level", level, 0);
      applyStimulus(0, 16'h0, '0, 0, 3'd0);
      io_resetn = 1'b1;
      tick();

      // Drop-on-full instance
      sel = 1'b1;
      #1;
      for (int b = 0; b < 3; b++) begin
         applyStimulus(1, 16'hFFFF, seqData(8'h20), 0, 3'd0);
         tick();
      end
      applyStimulus(1, 16'h0FFF, seqData(8'h20), 0, 3'd0);
      tick();
      checkOutput("dr_level60", level, 60);
      applyStimulus(1, 16'h00FF, seqData(8'h70), 0, 3'd0);
      checkOutput("dr_ready", push_ready, 1);
      tick();
      checkOutput("dr_overflow", overflow, 1);
      checkOutput("dr_drop1", drop_cnt, 1);
      checkOutput("dr_level_kept", level, 60);
      applyStimulus(1, 16'h000F, seqData(8'h50), 0, 3'd0);
      tick();
      checkOutput("dr_level64", level, 64);
      checkOutput("dr_full", full, 1);
      checkOutput("dr_drop_still1", drop_cnt, 1);
      applyStimulus(1, 16'h0001, seqData(8'h90), 0, 3'd0);
      checkOutput("dr_ready_full", push_ready, 1);
      tick();
      checkOutput("dr_drop2", drop_cnt, 2);
      checkOutput("dr_level_full", level, 64);
      for (int k = 0; k < 16; k++) begin
         applyStimulus(0, 16'h0, '0, 1, 3'd4);
         tick();
      end
      checkOutput("dr_tail_data", rd_data, 32'h53525150);
      checkOutput("dr_drained", level, 0);
      checkOutput("dr_drained_empty", empty, 1);

      clear = 1'b1;
      applyStimulus(1, 16'h0003, seqData(8'h80), 1, 3'd0);
      checkOutput("dr_clear_ack", pop_ack, 0);
      tick();
      clear = 1'b0;
      applyStimulus(0, 16'h0, '0, 0, 3'd0);
      checkOutput("dr_clear_level", level, 0);
      checkOutput("dr_clear_overflow", overflow, 0);
      checkOutput("dr_clear_drop", drop_cnt, 0);
      checkOutput("dr_clear_rd_valid", rd_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
